// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit with a
// single-entry registered output. Optional per-requester grant counters: LOGIC_ARB_GRANT_CNT_EN.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_id
`ifdef LOGIC_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_result;
  logic             r_id;

  logic             w_can_accept;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // Round-robin grant: on contention the requester that did not win last time goes next.
  always_comb begin
    w_can_accept = (r_state == ST_EMPTY) || out_ready;
    w_grant0     = req0_valid && (!req1_valid || r_last_grant);
    w_grant1     = req1_valid && (!req0_valid || !r_last_grant);
    req0_ready   = w_grant0 && w_can_accept;
    req1_ready   = w_grant1 && w_can_accept;
    w_accept     = req0_ready || req1_ready;
  end

  // Shared logic unit operating on the granted requester's operands.
  always_comb begin
    w_op     = w_grant1 ? req1_op : req0_op;
    w_a      = w_grant1 ? req1_a  : req0_a;
    w_b      = w_grant1 ? req1_b  : req0_b;
    w_result = '0;
    case (w_op)
      OP_XOR:  w_result = w_a ^ w_b;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XNOR: w_result = ~(w_a ^ w_b);
      default: w_result = '0;
    endcase
  end

  // Output register FSM; a drain and an accept in the same cycle keeps the entry FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_result     <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!w_accept && out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_accept) begin
        r_result     <= w_result;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
    end
  end

  assign out_valid  = (r_state == ST_FULL);
  assign out_result = r_result;
  assign out_id     = r_id;

`ifdef LOGIC_ARB_GRANT_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Free-running accept counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (req1_ready) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: reference model with a one-entry
// scoreboard queue, a table of single-request vectors and hand-written corner sequences.
module tb_logic_unit_arbiter;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_id;
`ifdef LOGIC_ARB_GRANT_CNT_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_id(out_id)
`ifdef LOGIC_ARB_GRANT_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  typedef struct {
    logic         v0, v1;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         exp_id;
    logic [W-1:0] exp_res;
  } vec_t;

  exp_t        sb[$];
  logic        m_last;
  logic [15:0] m_cnt0, m_cnt1;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [W-1:0] rep16(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic model_reset();
    sb.delete();
    m_last = 1'b1;
    m_cnt0 = '0;
    m_cnt1 = '0;
  endtask

  // One clock of stimulus: drive, compare at negedge against the model, advance model on posedge.
  task automatic step(input logic v0, input logic v1, input logic [1:0] op0, input logic [1:0] op1,
                      input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic ordy);
    logic can, g0, g1;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    out_ready  = ordy;
    @(negedge clk);
    can = (sb.size() == 0) || ordy;
    g0  = v0 && (!v1 || m_last);
    g1  = v1 && (!v0 || !m_last);
    check("req0_ready", W'(req0_ready), W'(g0 && can));
    check("req1_ready", W'(req1_ready), W'(g1 && can));
    check("out_valid", W'(out_valid), W'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_result", out_result, sb[0].res);
      check("out_id", W'(out_id), W'(sb[0].id));
    end
`ifdef LOGIC_ARB_GRANT_CNT_EN
    check("grant_cnt0", W'(grant_cnt0), W'(m_cnt0));
    check("grant_cnt1", W'(grant_cnt1), W'(m_cnt1));
`endif
    @(posedge clk);
    if (sb.size() != 0 && ordy) void'(sb.pop_front());
    if (g0 && can) begin
      sb.push_back('{id: 1'b0, res: ref_op(op0, a0, b0)});
      m_last = 1'b0;
      m_cnt0 = m_cnt0 + 16'd1;
    end else if (g1 && can) begin
      sb.push_back('{id: 1'b1, res: ref_op(op1, a1, b1)});
      m_last = 1'b1;
      m_cnt1 = m_cnt1 + 16'd1;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0, ordy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_result", out_result, '0);
    check("rst_out_id", W'(out_id), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  vec_t vecs[5];
  logic [W-1:0] held;
  logic [W-1:0] aa, cc;

  initial begin
    aa = rep16(16'hAAAA);
    cc = rep16(16'hCCCC);
    vecs[0] = '{1'b1, 1'b0, 2'b00, 2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
                '0, '0, 1'b0, 64'hF0F0_0F0F_F0F0_0F0F};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 2'b00, aa, cc, '0, '0, 1'b0, rep16(16'h8888)};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 2'b10, '0, '0, aa, cc, 1'b1, rep16(16'hEEEE)};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 2'b00, aa, cc, '0, '0, 1'b0, rep16(16'h9999)};
    vecs[4] = '{1'b0, 1'b1, 2'b00, 2'b00, '0, '0, aa, cc, 1'b1, rep16(16'h6666)};

    req0_valid = 1'b0; req1_valid = 1'b0; req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Contention straight out of reset: 0,1,0,1 at one result per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 2'b00, 2'b01, rep16(16'(i)), '1, rep16(16'(i + 16)), '1, 1'b1);
      check("rr_out_id", W'(out_id), W'(i % 2));
      check("rr_out_valid", W'(out_valid), W'(1));
    end
    idle(1'b1);

    // Table of single requests: result and owner one cycle after the accept.
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].v0, vecs[i].v1, vecs[i].op0, vecs[i].op1,
           vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, 1'b1);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_res);
      check($sformatf("vec%0d_id", i), W'(out_id), W'(vecs[i].exp_id));
    end
    idle(1'b1);

    // Backpressure: fill, then hold out_ready low with both valid and changing operands.
    step(1'b1, 1'b0, 2'b01, 2'b00, aa, cc, '0, '0, 1'b0);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'(i), 2'(i + 1), rep16(16'(i * 7)), '1, '1, rep16(16'(i)), 1'b0);
      check("bp_hold", out_result, held);
    end
    step(1'b1, 1'b1, 2'b10, 2'b11, aa, cc, aa, cc, 1'b1);
    check("bp_release_id", W'(out_id), W'(1));
    check("bp_release_result", out_result, rep16(16'h9999));
    idle(1'b0);
    idle(1'b1);

    // Asynchronous reset while FULL discards the result between clock edges.
    step(1'b0, 1'b1, 2'b00, 2'b00, '0, '0, aa, cc, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", W'(out_valid), '0);
    check("async_rst_result", out_result, '0);
    model_reset();
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);
    step(1'b1, 1'b1, 2'b01, 2'b10, aa, cc, aa, cc, 1'b1);
    check("post_rst_first_id", W'(out_id), '0);
    idle(1'b1);
    idle(1'b1);

`ifdef LOGIC_ARB_GRANT_CNT_EN
    // 65536 back-to-back req1 accepts wrap its counter to the same value; req0's is untouched.
    begin
      logic [15:0] c0, c1;
      step(1'b0, 1'b1, 2'b00, 2'b00, '0, '0, aa, cc, 1'b1);
      c0 = m_cnt0;
      c1 = m_cnt1;
      repeat (65536) @(posedge clk);
      #1;
      req1_valid = 1'b0;
      check("wrap_cnt1", W'(grant_cnt1), W'(c1));
      check("wrap_cnt0", W'(grant_cnt0), W'(c0));
      check("wrap_out_id", W'(out_id), W'(1));
      idle(1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0 / 1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  request accepted this cycle when ready and valid are both high.
REQ-006 req0_op / req1_op  input  2  operation code: 00 XOR, 01 AND, 10 OR, 11 XNOR.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 out_valid  output  1  result register holds a valid result.
REQ-009 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-010 out_result  output  WIDTH  registered result.
REQ-011 out_id  output  1  requester index that owns out_result.

Function
REQ-012 The block SHALL contain one shared bitwise logic unit and one single-entry output register; state is EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-013 can_accept = !out_valid || out_ready; at most one request SHALL be accepted per cycle.
REQ-014 Arbitration: if only one reqN_valid is high, it is granted; if both are high, the requester other than last_grant SHALL be granted (round-robin).
REQ-015 reqN_ready = grantN && can_accept; the path is combinational, and ready SHALL NOT be asserted for a requester whose valid is low.
REQ-016 last_grant SHALL update only on an accepted request.
REQ-017 Latency: the result for a request accepted in cycle T SHALL appear on out_result/out_id with out_valid=1 in cycle T+1.
REQ-018 Result: bitwise op over all WIDTH bits, with no carry and no inter-bit dependence; XNOR = ~(a^b).
REQ-019 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL stays FULL on simultaneous drain and accept (back-to-back), with the new result loaded.
REQ-020 FULL with out_ready=0: out_result/out_id SHALL hold stable, and both reqN_ready SHALL be 0.
REQ-021 Sustained throughput with out_ready held high SHALL be one result per cycle, alternating 0,1,0,1 when both requesters remain valid.
REQ-022 Operands and op SHALL be sampled only on the accept edge; later input changes SHALL NOT affect a held result.

Reset
REQ-023 While rst_n=0: out_valid=0, out_result=0, out_id=0, and last_grant=1, so requester 0 wins the first contention.
REQ-024 Reset asserted mid-operation SHALL immediately discard any held result, with no completion after release.
REQ-025 The first accept SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro LOGIC_ARB_GRANT_CNT_EN defined: the block SHALL add outputs grant_cnt0 and grant_cnt1, each 16 bits.
REQ-027 Each counter SHALL increment on every accept for its requester, wrap from 0xFFFF to 0x0000, and reset to 0.
REQ-028 Macro undefined: the block SHALL have no counter ports or logic, and all other behaviour SHALL be identical.

Verification
REQ-029 Single request: req0 op=00, a=0xFFFF_0000_FFFF_0000, b=0x0F0F_0F0F_0F0F_0F0F, out_ready=1 -> next cycle out_valid=1, out_result=0xF0F0_0F0F_F0F0_0F0F, out_id=0.
REQ-030 Contention after reset: both valid for 4 cycles with out_ready=1 -> out_id sequence 0,1,0,1; one result per cycle.
REQ-031 Backpressure: out_ready=0 with FULL and both valid for 5 cycles -> out_result stable and req0_ready=req1_ready=0; on out_ready=1, the same cycle accepts the next request.
REQ-032 All ops: a=0xAAAA..., b=0xCCCC..., ops 01/10/11 -> results 0x8888..., 0xEEEE..., 0x9999....
REQ-033 Reset mid-operation: rst_n pulsed low while FULL -> out_valid=0 asynchronously, without waiting for clk; after release, both valid -> req0 granted first.
REQ-034 With LOGIC_ARB_GRANT_CNT_EN: preload via 65536 req1 accepts -> grant_cnt1 wraps to 0, and grant_cnt0 is unchanged.
